// File: rtl/posit_serial_pkg.sv
// Shared definitions for the bit-serial posit decoder: FSM states and the
// derived output widths.
package posit_serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REGIME,
        EXP,
        FRAC,
        DONE
    } state_t;

    function automatic int exp_width(input int width, input int es);
        return $clog2(width) + es + 1;
    endfunction

    function automatic int frac_width(input int width, input int es);
        return ((width - 3 - es) < 1) ? 1 : (width - 3 - es);
    endfunction

endpackage

// File: rtl/posit_serial_decode.sv
// Bit-serial posit unpacker: accepts one packed posit, walks its bits MSB first
// (regime, exponent, fraction) one per cycle and presents the unpacked fields.
module posit_serial_decode
    import posit_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ES = 1,
    localparam int EXP_WIDTH = exp_width(WIDTH, ES),
    localparam int FRAC_WIDTH = frac_width(WIDTH, ES)
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_bits,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_sign,
    output logic                        out_is_zero,
    output logic                        out_is_inf,
    output logic signed [EXP_WIDTH-1:0] out_exp,
    output logic [FRAC_WIDTH-1:0]       out_frac
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int EW = (ES > 0) ? ES : 1;

    state_t                state, state_nx;
    logic [WIDTH-1:0]      sreg;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         run;
    logic [CW-1:0]         ecnt;
    logic [CW-1:0]         fcnt;
    logic                  r0;
    logic [EW-1:0]         e_q;
    logic [FRAC_WIDTH-1:0] frac_q;
    logic                  sign_q;
    logic                  zero_q;
    logic                  inf_q;

    logic                  cur_bit;
    logic                  special;
    logic                  last_bit;
    logic [EW-1:0]         e_mask;
    logic [FRAC_WIDTH-1:0] f_mask;
    logic signed [EXP_WIDTH-1:0] e_ext;

    // Regime contribution k: run-1 for a run of ones, -run for a run of zeros.
    function automatic logic signed [EXP_WIDTH-1:0] regime_k(input logic [CW-1:0] r,
                                                              input logic ones);
        logic signed [EXP_WIDTH-1:0] rr;
        rr = EXP_WIDTH'(r);
        return ones ? (rr - EXP_WIDTH'(1)) : -rr;
    endfunction

    assign cur_bit  = sreg[WIDTH-2];
    assign special  = (in_bits[WIDTH-2:0] == '0);
    assign last_bit = (cnt == CW'(1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = special ? DONE : REGIME;
                end
            end
            REGIME: begin
                if (last_bit) begin
                    state_nx = DONE;
                end else if ((run != '0) && (cur_bit != r0)) begin
                    if (ES > 0) state_nx = EXP;
                    else        state_nx = FRAC;
                end
            end
            EXP: begin
                if (last_bit) begin
                    state_nx = DONE;
                end else if (ecnt == CW'(ES - 1)) begin
                    state_nx = FRAC;
                end
            end
            FRAC: begin
                if (last_bit) state_nx = DONE;
            end
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // One-hot landing positions for the next exponent / fraction bit, MSB first.
    always_comb begin
        e_mask = '0;
        f_mask = '0;
        for (int i = 0; i < EW; i++) begin
            if (i == ES - 1 - int'(ecnt)) e_mask[i] = 1'b1;
        end
        for (int i = 0; i < FRAC_WIDTH; i++) begin
            if (i == FRAC_WIDTH - 1 - int'(fcnt)) f_mask[i] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sreg   <= '0;
            cnt    <= '0;
            run    <= '0;
            ecnt   <= '0;
            fcnt   <= '0;
            r0     <= 1'b0;
            e_q    <= '0;
            frac_q <= '0;
            sign_q <= 1'b0;
            zero_q <= 1'b0;
            inf_q  <= 1'b0;
        end else begin
            if ((state == IDLE) && in_valid) begin
                sign_q <= in_bits[WIDTH-1] && !special;
                zero_q <= special && !in_bits[WIDTH-1];
                inf_q  <= special && in_bits[WIDTH-1];
                sreg   <= in_bits[WIDTH-1] ? -in_bits : in_bits;
                cnt    <= special ? '0 : CW'(WIDTH - 1);
                run    <= '0;
                ecnt   <= '0;
                fcnt   <= '0;
                r0     <= 1'b0;
                e_q    <= '0;
                frac_q <= '0;
            end
            if ((state == REGIME) || (state == EXP) || (state == FRAC)) begin
                sreg <= sreg << 1;
                cnt  <= cnt - CW'(1);
            end
            if (state == REGIME) begin
                if (run == '0) begin
                    r0  <= cur_bit;
                    run <= CW'(1);
                end else if (cur_bit == r0) begin
                    run <= run + CW'(1);
                end
            end
            if (state == EXP) begin
                if (cur_bit) e_q <= e_q | e_mask;
                ecnt <= ecnt + CW'(1);
            end
            if (state == FRAC) begin
                if (cur_bit) frac_q <= frac_q | f_mask;
                fcnt <= fcnt + CW'(1);
            end
        end
    end

    assign e_ext       = EXP_WIDTH'(e_q);
    assign out_exp     = (regime_k(run, r0) <<< ES) + e_ext;
    assign out_frac    = frac_q;
    assign out_sign    = sign_q;
    assign out_is_zero = zero_q;
    assign out_is_inf  = inf_q;

endmodule

// File: tb/tb_posit_serial_decode.sv
// Self-checking bench for posit_serial_decode (WIDTH=8, ES=1) with a
// field-level reference decoder.
module tb_posit_serial_decode;

    localparam int W    = 8;
    localparam int ES   = 1;
    localparam int EXPW = 5;
    localparam int FW   = 4;

    logic                   clock = 1'b0;
    logic                   resetn = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [W-1:0]           in_bits = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic                   out_sign;
    logic                   out_is_zero;
    logic                   out_is_inf;
    logic signed [EXPW-1:0] out_exp;
    logic [FW-1:0]          out_frac;

    int checks = 0;
    int fails  = 0;
    int n_acc  = 0;
    int n_res  = 0;
    int n_vld  = 0;

    posit_serial_decode #(.WIDTH(W), .ES(ES)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bits    (in_bits),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_is_zero(out_is_zero),
        .out_is_inf (out_is_inf),
        .out_exp    (out_exp),
        .out_frac   (out_frac)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (in_valid && in_ready) n_acc++;
        if (out_valid && out_ready) n_res++;
        if (out_valid) n_vld++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    // Reference: read the magnitude's bits MSB first as regime run, terminator,
    // ES exponent bits, then fraction; missing bits count as zero.
    task automatic ref_decode(input logic [W-1:0] x, output logic s, output logic z,
                              output logic inf, output int e, output logic [FW-1:0] f);
        logic [W-1:0] v;
        int i, run, k, ev;
        logic rb;
        s = 1'b0; z = (x == 8'h00); inf = (x == 8'h80); e = 0; f = '0;
        if (!z && !inf) begin
            s = x[W-1];
            v = s ? 8'(-x) : x;
            i = W - 2;
            rb = v[i];
            run = 0;
            while (i >= 0 && v[i] == rb) begin run++; i--; end
            if (i >= 0) i--;
            k = rb ? run - 1 : -run;
            ev = 0;
            for (int j = ES - 1; j >= 0; j--) begin
                if (i >= 0) begin ev += int'(v[i]) * (1 << j); i--; end
            end
            for (int j = FW - 1; j >= 0; j--) begin
                if (i >= 0) begin f[j] = v[i]; i--; end
            end
            e = k * (1 << ES) + ev;
        end
    endtask

    // Offer one word, then wait for its result; lat counts cycles after acceptance.
    task automatic run_word(input logic [W-1:0] w, input bit noise, output int lat,
                            output logic s, output logic z, output logic inf,
                            output int e, output logic [FW-1:0] f);
        int guard = 0;
        while (!in_ready && guard < 50) begin @(posedge clock); #1; guard++; end
        in_valid = 1'b1;
        in_bits  = w;
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_bits  = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (noise) begin
                in_valid = 1'($urandom);
                in_bits  = 8'($urandom);
            end
            @(posedge clock); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        s = out_sign; z = out_is_zero; inf = out_is_inf;
        e = int'(out_exp); f = out_frac;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        #1 resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        checks++;
        if (out_exp !== '0 || out_frac !== '0 || out_sign !== 1'b0 ||
            out_is_zero !== 1'b0 || out_is_inf !== 1'b0) begin
            fails++;
            $display("FAIL reset_fields: exp=%0d frac=%b s=%b z=%b i=%b, required all 0",
                     out_exp, out_frac, out_sign, out_is_zero, out_is_inf);
        end
        @(negedge clock) resetn = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] words [8] = '{8'h40, 8'h48, 8'h50, 8'hC0, 8'h01, 8'h7F, 8'h00, 8'h80};
        int           exps  [8] = '{0, 0, 1, 0, -12, 12, 0, 0};
        logic [FW-1:0] fracs[8] = '{4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic         sgns  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic         zs    [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic         infs  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int           lats  [8] = '{8, 8, 8, 8, 8, 8, 1, 1};
        int lat, e;
        logic s, z, inf;
        logic [FW-1:0] f;
        for (int n = 0; n < 8; n++) begin
            run_word(words[n], 1'b0, lat, s, z, inf, e, f);
            checks++;
            if (lat !== lats[n]) begin
                fails++;
                $display("FAIL directed_latency %h: got %0d, required %0d", words[n], lat, lats[n]);
            end
            checks++;
            if (s !== sgns[n] || z !== zs[n] || inf !== infs[n] || e !== exps[n] || f !== fracs[n]) begin
                fails++;
                $display("FAIL directed_fields %h: s=%b z=%b i=%b exp=%0d frac=%b, required s=%b z=%b i=%b exp=%0d frac=%b",
                         words[n], s, z, inf, e, f, sgns[n], zs[n], infs[n], exps[n], fracs[n]);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        int lat, e, re;
        logic s, z, inf, rs, rz, ri;
        logic [FW-1:0] f, rf;
        ref_decode(8'h48, rs, rz, ri, re, rf);
        run_word(8'h48, 1'b1, lat, s, z, inf, e, f);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_bits  = 8'($urandom);
            @(posedge clock); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'(out_exp) !== re ||
                out_frac !== rf || out_sign !== rs) begin
                fails++;
                $display("FAIL backpressure_hold c%0d: vld=%b rdy=%b exp=%0d frac=%b s=%b, required 1/0 exp=%0d frac=%b s=%b",
                         c, out_valid, in_ready, out_exp, out_frac, out_sign, re, rf, rs);
            end
        end
        in_valid = 1'b0;
        handshake();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int v0, lat, e;
        logic s, z, inf;
        logic [FW-1:0] f;
        v0 = n_vld;
        in_valid = 1'b1;
        in_bits  = 8'h48;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1 resetn = 1'b0;
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_exp !== '0 || out_frac !== '0) begin
            fails++;
            $display("FAIL midreset_state: rdy=%b vld=%b exp=%0d frac=%b, required 1/0/0/0",
                     in_ready, out_valid, out_exp, out_frac);
        end
        @(negedge clock) resetn = 1'b1;
        repeat (12) @(posedge clock);
        #1;
        checks++;
        if (n_vld !== v0) begin
            fails++;
            $display("FAIL midreset_no_output: out_valid seen %0d cycles, required 0", n_vld - v0);
        end
        run_word(8'h40, 1'b0, lat, s, z, inf, e, f);
        checks++;
        if (lat !== 8 || s !== 1'b0 || e !== 0 || f !== 4'b0000 || z !== 1'b0 || inf !== 1'b0) begin
            fails++;
            $display("FAIL midreset_next_word: lat=%0d s=%b exp=%0d frac=%b, required 8/0/0/0000", lat, s, e, f);
        end
        handshake();
    endtask

    task automatic test_sweep();
        int a0, r0, lat, e, re, rlat;
        logic s, z, inf, rs, rz, ri;
        logic [FW-1:0] f, rf;
        a0 = n_acc;
        r0 = n_res;
        for (int w = 0; w < 256; w++) begin
            ref_decode(8'(w), rs, rz, ri, re, rf);
            rlat = (rz || ri) ? 1 : W;
            run_word(8'(w), 1'b0, lat, s, z, inf, e, f);
            checks++;
            if (lat !== rlat || s !== rs || z !== rz || inf !== ri || e !== re || f !== rf) begin
                fails++;
                $display("FAIL sweep %h: lat=%0d s=%b z=%b i=%b exp=%0d frac=%b, required lat=%0d s=%b z=%b i=%b exp=%0d frac=%b",
                         w, lat, s, z, inf, e, f, rlat, rs, rz, ri, re, rf);
            end
            handshake();
        end
        checks++;
        if ((n_acc - a0) !== 256 || (n_res - r0) !== 256) begin
            fails++;
            $display("FAIL sweep_counts: accepted=%0d results=%0d, required 256/256", n_acc - a0, n_res - r0);
        end
    endtask

    task automatic test_random();
        int lat, e, re, rlat, stall;
        logic [W-1:0] w;
        logic s, z, inf, rs, rz, ri;
        logic [FW-1:0] f, rf;
        for (int n = 0; n < 40; n++) begin
            w = 8'($urandom_range(0, 255));
            stall = $urandom_range(0, 3);
            ref_decode(w, rs, rz, ri, re, rf);
            rlat = (rz || ri) ? 1 : W;
            run_word(w, 1'b1, lat, s, z, inf, e, f);
            checks++;
            if (lat !== rlat || s !== rs || z !== rz || inf !== ri || e !== re || f !== rf) begin
                fails++;
                $display("FAIL random %h: lat=%0d s=%b z=%b i=%b exp=%0d frac=%b, required lat=%0d s=%b z=%b i=%b exp=%0d frac=%b",
                         w, lat, s, z, inf, e, f, rlat, rs, rz, ri, re, rf);
            end
            repeat (stall) @(posedge clock);
            #1;
            checks++;
            if (out_valid !== 1'b1 || int'(out_exp) !== re || out_frac !== rf) begin
                fails++;
                $display("FAIL random_stall %h: vld=%b exp=%0d frac=%b, required 1 exp=%0d frac=%b",
                         w, out_valid, out_exp, out_frac, re, rf);
            end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
